// File: rtl/fpga_link_pkg.sv
// Shared definitions for the FPGA-to-FPGA serial link (receive and transmit sides).
package fpga_link_pkg;

  // Receiver control states; the transmit side reuses the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } link_state_t;

  // Frame shape: start bit, DATA_BITS data bits LSB first, one stop bit, no parity.
  localparam int   DATA_BITS   = 8;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/fpga_bit_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clock domain.
module fpga_bit_sync #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Both flops come out of reset at the line's idle level so no false edge is seen.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta     <= RESET_LEVEL;
      sync_out <= RESET_LEVEL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/fpga_serial_receiver.sv
// Serial byte receiver: start-bit qualification, mid-bit sampling, stop check and handshake.
module fpga_serial_receiver
  import fpga_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in_s,
  input  logic       ack,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  link_state_t            state;
  link_state_t            next_state;
  logic                   line;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   baud_clear;
  logic                   bit_clear;
  logic                   shift_en;
  logic                   byte_done;
  logic                   frame_err;

  fpga_bit_sync #(
    .RESET_LEVEL (IDLE_LEVEL)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (data_in_s),
    .sync_out (line)
  );

  assign busy = (state != ST_IDLE);

  // State register; reset abandons any partial frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the per-cycle strobes that steer the counters and outputs.
  always_comb begin
    next_state = state;
    baud_clear = 1'b0;
    bit_clear  = 1'b0;
    shift_en   = 1'b0;
    byte_done  = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_clear = 1'b1;
        if (line == START_LEVEL) begin
          bit_clear  = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_clear = 1'b1;
          next_state = (line == START_LEVEL) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        if (baud_cnt == FULL_LAST) begin
          baud_clear = 1'b1;
          shift_en   = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            next_state = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (baud_cnt == FULL_LAST) begin
          baud_clear = 1'b1;
          if (line == STOP_LEVEL) begin
            byte_done  = 1'b1;
            next_state = ST_IDLE;
          end else begin
            frame_err  = 1'b1;
            next_state = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        baud_clear = 1'b1;
        if (line == IDLE_LEVEL) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Baud and bit counters plus the LSB-first shift register (new bits enter at the MSB).
  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      baud_cnt <= baud_clear ? '0 : baud_cnt + BAUD_W'(1);
      if (bit_clear) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (shift_en) begin
        shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
      end
    end
  end

  // Consumer-facing flags: ack clears first, then a completed byte may set them again.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out      <= 8'h00;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (ack) begin
        data_ready <= 1'b0;
        overrun    <= 1'b0;
      end
      if (byte_done) begin
        data_out      <= shift_reg;
        data_ready    <= 1'b1;
        framing_error <= 1'b0;
        if (data_ready && !ack) begin
          overrun <= 1'b1;
        end
      end
      if (frame_err) begin
        framing_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpga_serial_receiver.sv
// Self-checking bench for fpga_serial_receiver with a timeline-based reference model.
module tb_fpga_serial_receiver;

  localparam int N = 8;
  localparam int H = N / 2;

  logic       clock;
  logic       reset;
  logic       data_in_s;
  logic       ack;
  logic [7:0] data_out;
  logic       data_ready;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  fpga_serial_receiver #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in_s     (data_in_s),
    .ack           (ack),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one value and log it.
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive a full frame on the line: start, 8 data bits LSB first, stop (good or bad), then idle.
  task automatic applyStimulus(input logic [7:0] value, input logic stop_ok);
    data_in_s = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      data_in_s = value[i];
      tick(N);
    end
    data_in_s = stop_ok;
    tick(N);
    data_in_s = 1'b1;
  endtask

  // Reference model: the line as the receiver sees it after a two-cycle delay, decoded by
  // looking back at sample points measured as offsets from the detected falling edge.
  int         edge_no     = 0;
  int         frame_start = -1;
  bit         waiting     = 1'b0;
  bit         compare_en  = 1'b0;
  logic       m_sync1, m_sync2;
  logic       hist [1024];
  logic [7:0] exp_out;
  logic       exp_ready, exp_fe, exp_overrun, exp_busy;

  always @(posedge clock) begin
    logic       s;
    logic       old_ready;
    logic [7:0] rx_byte;
    int         off;
    s = m_sync2;
    edge_no++;
    if (reset) begin
      m_sync1     = 1'b1;
      m_sync2     = 1'b1;
      frame_start = -1;
      waiting     = 1'b0;
      exp_out     = 8'h00;
      exp_ready   = 1'b0;
      exp_fe      = 1'b0;
      exp_overrun = 1'b0;
      compare_en  = 1'b1;
    end else begin
      hist[edge_no % 1024] = s;
      old_ready = exp_ready;
      if (ack) begin
        exp_ready   = 1'b0;
        exp_overrun = 1'b0;
      end
      if (frame_start < 0 && !waiting) begin
        if (s == 1'b0) frame_start = edge_no;
      end else if (waiting) begin
        if (s == 1'b1) waiting = 1'b0;
      end else begin
        off = edge_no - frame_start;
        if (off == H && s == 1'b1) begin
          frame_start = -1;
        end else if (off == H + 9 * N) begin
          for (int k = 0; k < 8; k++)
            rx_byte[k] = hist[(frame_start + H + (k + 1) * N) % 1024];
          if (s) begin
            exp_out   = rx_byte;
            exp_ready = 1'b1;
            exp_fe    = 1'b0;
            if (old_ready && !ack) exp_overrun = 1'b1;
          end else begin
            exp_fe  = 1'b1;
            waiting = 1'b1;
          end
          frame_start = -1;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = data_in_s;
    end
    exp_busy = (frame_start >= 0) || waiting;
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clock) begin
    if (compare_en) begin
      checkOutput("data_out", data_out, exp_out);
      checkOutput("data_ready", {7'd0, data_ready}, {7'd0, exp_ready});
      checkOutput("framing_error", {7'd0, framing_error}, {7'd0, exp_fe});
      checkOutput("overrun", {7'd0, overrun}, {7'd0, exp_overrun});
      checkOutput("busy", {7'd0, busy}, {7'd0, exp_busy});
    end
  end

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with literal expectations, then a randomized phase.
  initial begin
    logic [7:0] b;
    logic       ok;
    int         gap;
    reset     = 1'b1;
    data_in_s = 1'b1;
    ack       = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);
    checkOutput("reset data_out", data_out, 8'h00);
    checkOutput("reset busy", {7'd0, busy}, 8'h00);

    applyStimulus(8'hA5, 1'b1);
    checkOutput("A5 data_out", data_out, 8'hA5);
    checkOutput("A5 data_ready", {7'd0, data_ready}, 8'h01);
    checkOutput("A5 framing_error", {7'd0, framing_error}, 8'h00);
    checkOutput("A5 overrun", {7'd0, overrun}, 8'h00);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checkOutput("A5 ack clears ready", {7'd0, data_ready}, 8'h00);
    tick(3);

    data_in_s = 1'b0;
    tick(2);
    data_in_s = 1'b1;
    tick(12);
    checkOutput("glitch busy", {7'd0, busy}, 8'h00);
    checkOutput("glitch data_ready", {7'd0, data_ready}, 8'h00);
    checkOutput("glitch data_out", data_out, 8'hA5);

    applyStimulus(8'h3C, 1'b0);
    checkOutput("bad stop framing_error", {7'd0, framing_error}, 8'h01);
    checkOutput("bad stop data_ready", {7'd0, data_ready}, 8'h00);
    tick(4);
    applyStimulus(8'h3C, 1'b1);
    checkOutput("3C data_out", data_out, 8'h3C);
    checkOutput("3C framing_error", {7'd0, framing_error}, 8'h00);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;

    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    checkOutput("overrun data_out", data_out, 8'h22);
    checkOutput("overrun data_ready", {7'd0, data_ready}, 8'h01);
    checkOutput("overrun flag", {7'd0, overrun}, 8'h01);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    checkOutput("overrun ack ready", {7'd0, data_ready}, 8'h00);
    checkOutput("overrun ack flag", {7'd0, overrun}, 8'h00);

    applyStimulus(8'h44, 1'b1);
    fork
      applyStimulus(8'h55, 1'b1);
      begin
        tick(H + 9 * N + 2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    join
    checkOutput("same-cycle ack data_out", data_out, 8'h55);
    checkOutput("same-cycle ack data_ready", {7'd0, data_ready}, 8'h01);
    checkOutput("same-cycle ack overrun", {7'd0, overrun}, 8'h00);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;

    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        tick(5 * N + 4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        checkOutput("mid-frame reset data_out", data_out, 8'h00);
        checkOutput("mid-frame reset data_ready", {7'd0, data_ready}, 8'h00);
        checkOutput("mid-frame reset framing_error", {7'd0, framing_error}, 8'h00);
        checkOutput("mid-frame reset overrun", {7'd0, overrun}, 8'h00);
        checkOutput("mid-frame reset busy", {7'd0, busy}, 8'h00);
      end
    join
    tick(3);
    applyStimulus(8'h0F, 1'b1);
    checkOutput("after reset data_out", data_out, 8'h0F);
    checkOutput("after reset data_ready", {7'd0, data_ready}, 8'h01);

    for (int f = 0; f < 40; f++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 4) != 0);
      fork
        applyStimulus(b, ok);
        repeat (10 * N) begin
          ack = ($urandom_range(0, 5) == 0);
          tick(1);
        end
      join
      ack = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        data_in_s = 1'b0;
        tick($urandom_range(1, H - 1));
        data_in_s = 1'b1;
        tick(H + 4);
      end
      gap = $urandom_range(0, 20);
      if (gap > 0) tick(gap);
    end
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fpga_serial_receiver.md
FPGA_SERIAL_RECEIVER -- requirements
Module: fpga_serial_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: system clock cycles per serial bit; legal range 4..65535.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 data_in_s  input  1  serial line from the remote FPGA; asynchronous to clock; idles high.
REQ-005 ack  input  1  consumer acknowledge; clears data_ready and overrun.
REQ-006 data_out  output  8  last received byte.
REQ-007 data_ready  output  1  byte in data_out not yet acknowledged.
REQ-008 framing_error  output  1  last frame had a low stop bit; sticky until the next good frame or reset.
REQ-009 overrun  output  1  a byte was overwritten before ack; sticky until ack.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 Frame format: one low start bit, 8 data bits LSB first, one high stop bit, no parity.
REQ-012 data_in_s passes through a 2-flop synchronizer; all sampling uses the synchronized bit, giving 2 cycles of input latency.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-014 IDLE: synchronized line low -> START, bit counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample; low -> DATA; high -> IDLE (glitch rejected, no output change).
REQ-016 DATA: sample every CLKS_PER_BIT cycles and shift into an internal register from the MSB end; after the 8th sample -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; high -> load data_out, set data_ready, clear framing_error, go IDLE; low -> set framing_error, leave data_out/data_ready unchanged, go WAIT_IDLE.
REQ-018 WAIT_IDLE: stay until the synchronized line is high, then go IDLE.
REQ-019 data_out, data_ready and framing_error update in the cycle after the stop-bit sample.
REQ-020 ack with data_ready high clears data_ready and overrun the following cycle; ack with data_ready low clears overrun only.
REQ-021 Byte completion with data_ready high and ack low: overwrite data_out, keep data_ready high, set overrun.
REQ-022 Byte completion in the same cycle as ack: load the new byte, data_ready stays high, overrun not set.
REQ-023 The baud counter is $clog2(CLKS_PER_BIT)+1 bits wide and reloads to zero at each sample point; no wrap is otherwise allowed.

Reset
REQ-024 Reset forces IDLE, clears counters, shift register, data_out=8'h00, data_ready=0, framing_error=0, overrun=0, busy=0.
REQ-025 Reset takes priority over all inputs, including mid-frame; the partial frame is discarded.
REQ-026 Synchronizer flops reset to 1 (idle level), so no false start is detected after reset.

Structure
REQ-027 State encodings and the frame constants (DATA_BITS=8, STOP_LEVEL=1) belong in the shared FPGA-link package, which the transmit side also uses.
REQ-028 The 2-flop synchronizer is a separate sub-module, fpga_bit_sync; everything else lives in fpga_serial_receiver.

Verification (CLKS_PER_BIT=8)
REQ-029 Send 0xA5 with a good stop bit -> data_out=0xA5, data_ready=1, framing_error=0, overrun=0; ack -> data_ready=0 the next cycle.
REQ-030 Drive the line low for 2 cycles, then high -> state returns to IDLE, data_ready stays 0, data_out unchanged.
REQ-031 Send 0x3C with a low stop bit -> framing_error=1, data_ready=0; line high, then 0x3C with a good stop -> data_out=0x3C, framing_error=0.
REQ-032 Send 0x11 then 0x22 without ack -> data_out=0x22, data_ready=1, overrun=1; ack -> both clear.
REQ-033 Assert ack in the exact completion cycle of a second byte 0x55 -> data_out=0x55, data_ready=1, overrun=0.
REQ-034 Assert reset during data bit 4 of 0xFF, then send 0x0F -> first frame lost, all outputs zero after reset, then data_out=0x0F.
